// File: rtl/mips_core_pkg.sv
// Shared core definitions used by the front-end queues.
// Holds the default instruction-queue geometry and the {data, pc} entry layout.
package mips_core_pkg;

  localparam int INST_Q_DEPTH = 8;
  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] pc;
  } inst_q_entry_t;

endpackage

// File: rtl/instruction_queue.sv
// In-order fetch-to-decode FIFO with wrap-bit pointers, flush and overflow drop.
// Optional same-cycle empty-queue bypass when INST_Q_BYPASS_EN is defined.
module instruction_queue #(
  parameter int DEPTH      = mips_core_pkg::INST_Q_DEPTH,
  parameter int DATA_WIDTH = mips_core_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH,
  localparam int PW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic                  flush,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_full,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [PW-1:0]         count
);

  localparam int IW = PW - 1;

  mips_core_pkg::inst_q_entry_t mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          empty, full, byp, enq, deq;

  // Extra wrap bit makes the plain difference the occupancy, mod 2*DEPTH.
  assign count = tail_q - head_q;
  assign empty = (count == '0);
  assign full  = (count == PW'(DEPTH));

`ifdef INST_Q_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = ~empty | byp;
  assign out_full  = full;
  assign deq       = ~empty & out_ready;
  // A bypassed word taken by decode this cycle is never stored.
  assign enq       = in_valid & ~full & ~(byp & out_ready);

  always_comb begin
    out_data = '0;
    out_pc   = '0;
    if (!empty) begin
      out_data = mem_q[head_q[IW-1:0]].data;
      out_pc   = mem_q[head_q[IW-1:0]].pc;
    end else if (byp) begin
      out_data = in_data;
      out_pc   = in_pc;
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is deliberately not cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq) begin
      mem_q[tail_q[IW-1:0]].data <= in_data;
      mem_q[tail_q[IW-1:0]].pc   <= in_pc;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (rst || flush || !(in_valid && full))
      else $warning("instruction_queue: fetch word dropped while queue full");
  end
`endif

endmodule
